sweep_decoder: RTL

//  Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with enable.

---
 rtl/sweep_decoder.sv | 105 ++++++++++
 1 files changed

// File: rtl/sweep_decoder.sv
// Registered one-hot decoder with enable, plus a sweep mode that walks every
// output from SWEEP_START to the last index, one per cycle.
module sweep_decoder #(
   parameter int SEL_W       = 5,
   parameter int SWEEP_START = 0
) (
   input  logic                    clock,
   input  logic                    ctrl_reset,
   input  logic                    in_valid,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_enable,
   output logic                    in_ready,
   input  logic                    sweep_start,
   output logic                    busy,
   output logic [(1<<SEL_W)-1:0]   out_onehot,
   output logic                    out_valid,
   output logic [SEL_W-1:0]        out_index,
   output logic                    sweep_done
);

   localparam int OUTS = 2 ** SEL_W;
   localparam logic [SEL_W-1:0] START_IDX = SEL_W'(SWEEP_START);
   localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(OUTS - 1);

   generate
      if (SWEEP_START < 0 || SWEEP_START >= OUTS) begin : g_bad_start
         $error("sweep_decoder: SWEEP_START out of range 0..OUTS-1");
      end
   endgenerate

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t                 state, state_nxt;
   logic [SEL_W-1:0]       counter, counter_nxt;
   logic [SEL_W-1:0]       step_idx;
   logic [OUTS-1:0]        onehot_nxt;
   logic                   valid_nxt;
   logic [SEL_W-1:0]       index_nxt;
   logic                   done_nxt;

   // counter holds the index currently on the outputs, so the first sweep
   // output can appear on the cycle right after sweep_start is sampled
   always_comb begin
      state_nxt   = state;
      counter_nxt = counter;
      onehot_nxt  = '0;
      valid_nxt   = 1'b0;
      index_nxt   = out_index;
      done_nxt    = 1'b0;
      step_idx    = counter + 1'b1;
      in_ready    = ~ctrl_reset & (state == IDLE) & ~sweep_start;
      busy        = (state == SWEEP);

      case (state)
         IDLE: begin
            if (sweep_start) begin
               state_nxt   = SWEEP;
               counter_nxt = START_IDX;
               onehot_nxt  = OUTS'(1) << START_IDX;
               valid_nxt   = 1'b1;
               index_nxt   = START_IDX;
               done_nxt    = (START_IDX == LAST_IDX);
            end else if (in_valid) begin
               valid_nxt = 1'b1;
               index_nxt = in_sel;
               if (in_enable) begin
                  onehot_nxt = OUTS'(1) << in_sel;
               end
            end
         end
         SWEEP: begin
            if (counter == LAST_IDX) begin
               state_nxt   = IDLE;
               counter_nxt = START_IDX;
            end else begin
               counter_nxt = step_idx;
               onehot_nxt  = OUTS'(1) << step_idx;
               valid_nxt   = 1'b1;
               index_nxt   = step_idx;
               done_nxt    = (step_idx == LAST_IDX);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         state      <= IDLE;
         counter    <= START_IDX;
         out_onehot <= '0;
         out_valid  <= 1'b0;
         out_index  <= '0;
         sweep_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         counter    <= counter_nxt;
         out_onehot <= onehot_nxt;
         out_valid  <= valid_nxt;
         out_index  <= index_nxt;
         sweep_done <= done_nxt;
      end
   end

endmodule
